// File: rtl/vga_frame_transmitter.sv
// vga_frame_transmitter: 2-line ping-pong pixel buffer driving 640x480@60 VGA timing, sync and RGB.
// Optional VGA_TX_BORDER_BLANK_EN blanks the 1-pixel frame border that the Sobel stage cannot produce.
module vga_frame_transmitter #(
    parameter int P_FRAME_COLUMNS = 640,
    parameter int P_FRAME_ROWS    = 480,
    parameter int P_H_FP          = 16,
    parameter int P_H_SYNC        = 96,
    parameter int P_H_BP          = 48,
    parameter int P_V_FP          = 10,
    parameter int P_V_SYNC        = 2,
    parameter int P_V_BP          = 33,
    parameter int P_CLK_DIV       = 2,
    parameter int P_STORE_DEPTH   = 8,
    parameter int P_PIXEL_DEPTH   = 24
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET,
    input  logic                     I_ENABLE,
    input  logic [9:0]               I_PIXEL_COLUMN,
    input  logic [8:0]               I_PIXEL_ROW,
    input  logic [P_STORE_DEPTH-1:0] I_PIXEL,
    input  logic                     I_PIXEL_VALID,
    output logic                     O_PIXEL_CLK,
    output logic                     O_HSYNC,
    output logic                     O_VSYNC,
    output logic                     O_DATA_VALID,
    output logic [P_PIXEL_DEPTH-1:0] O_PIXEL,
    output logic                     O_FRAME_START,
    output logic                     O_LINE_START
);
    localparam int DW = $clog2(P_CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(P_CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(P_CLK_DIV / 2);
    localparam logic [9:0] H_ACT     = 10'(P_FRAME_COLUMNS);
    localparam logic [9:0] H_SYNC_LO = 10'(P_FRAME_COLUMNS + P_H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(P_FRAME_COLUMNS + P_H_FP + P_H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(P_FRAME_COLUMNS + P_H_FP + P_H_SYNC + P_H_BP - 1);
    localparam logic [9:0] V_ACT     = 10'(P_FRAME_ROWS);
    localparam logic [9:0] V_SYNC_LO = 10'(P_FRAME_ROWS + P_V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(P_FRAME_ROWS + P_V_FP + P_V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(P_FRAME_ROWS + P_V_FP + P_V_SYNC + P_V_BP - 1);

    logic [P_STORE_DEPTH-1:0] line_buf [2][P_FRAME_COLUMNS];
    logic [DW-1:0]            q_div, q_next;
    logic [9:0]               h, v;
    logic                     tick, de, hs_n, vs_n, blank, unused_row;
    logic [P_STORE_DEPTH-1:0] rd;

    always_comb begin
        tick       = q_div == DIV_LAST;
        q_next     = tick ? '0 : q_div + 1'b1;
        de         = h < H_ACT && v < V_ACT;
        hs_n       = !(h >= H_SYNC_LO && h < H_SYNC_HI);
        vs_n       = !(v >= V_SYNC_LO && v < V_SYNC_HI);
        rd         = line_buf[v[0]][h];
        unused_row = ^I_PIXEL_ROW[8:1];
`ifdef VGA_TX_BORDER_BLANK_EN
        blank = h == 10'd0 || h == H_ACT - 10'd1 || v == 10'd0 || v == V_ACT - 10'd1;
`else
        blank = 1'b0;
`endif
    end

    // Writes are independent of timing state, so upstream may prefill while idle.
    always_ff @(posedge I_CLK)
        if (I_PIXEL_VALID && I_PIXEL_COLUMN < H_ACT)
            line_buf[I_PIXEL_ROW[0]][I_PIXEL_COLUMN] <= I_PIXEL;

    // Pixel outputs register on the tick edge, which is also where O_PIXEL_CLK falls.
    always_ff @(posedge I_CLK) begin
        if (I_RESET || !I_ENABLE) begin
            q_div         <= '0;
            h             <= '0;
            v             <= '0;
            O_PIXEL_CLK   <= 1'b0;
            O_HSYNC       <= 1'b1;
            O_VSYNC       <= 1'b1;
            O_DATA_VALID  <= 1'b0;
            O_PIXEL       <= '0;
            O_FRAME_START <= 1'b0;
            O_LINE_START  <= 1'b0;
        end else begin
            q_div         <= q_next;
            O_PIXEL_CLK   <= q_next >= DIV_HALF;
            O_FRAME_START <= tick && h == 10'd0 && v == 10'd0;
            O_LINE_START  <= tick && h == 10'd0;
            if (tick) begin
                h            <= h == H_LAST ? 10'd0 : h + 10'd1;
                if (h == H_LAST)
                    v <= v == V_LAST ? 10'd0 : v + 10'd1;
                O_HSYNC      <= hs_n;
                O_VSYNC      <= vs_n;
                O_DATA_VALID <= de;
                O_PIXEL      <= (de && !blank) ? P_PIXEL_DEPTH'({3{rd}}) : '0;
            end
        end
    end
endmodule
